// File: rtl/data_mem_sync.sv
// Synchronous data memory for the RV32 MEM stage.
// Valid/ready request port, registered response, byte/half/word access with
// load extension. Accesses crossing a word boundary take a second cycle.
// Out-of-range and reserved-size requests answer with rsp_err and touch nothing.
//
// state | meaning
// IDLE  | ready for a request; aligned ops complete in one cycle
// SPLIT | finishing the upper word of a boundary-crossing access
module data_mem_sync #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h00001000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) << 2;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH_WORDS];

    // request decode
    logic [33:0]   off;
    logic [33:0]   end_off;
    logic [2:0]    nbytes;
    logic [3:0]    size_mask;
    logic          acc_err;
    logic          crossing;
    logic          accept;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [7:0]    be8;
    logic [63:0]   wdata64;

    // state carried from the first half of a split access
    logic [AW-1:0] sp_idx;
    logic          sp_we;
    logic [3:0]    sp_be_hi;
    logic [31:0]   sp_wdata_hi;
    logic [31:0]   sp_lo;
    logic [1:0]    sp_lane;
    logic [1:0]    sp_size;
    logic          sp_uns;

    // read and write ports
    logic [31:0]   rd_lo;
    logic [31:0]   rd_hi;
    logic [31:0]   ld_raw_lo;
    logic [63:0]   split64;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns);
        logic [31:0] r;
        case (size)
            2'd0:    r = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            2'd1:    r = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Decode range, size and lane placement of the incoming request.
    // The offset is kept 34 bits wide so addresses below BASE show up as
    // negative instead of wrapping into the array.
    always_comb begin
        off = {2'b00, req_addr} - {2'b00, BASE_ADDR};
        case (req_size)
            2'd0:    begin nbytes = 3'd1; size_mask = 4'b0001; end
            2'd1:    begin nbytes = 3'd2; size_mask = 4'b0011; end
            default: begin nbytes = 3'd4; size_mask = 4'b1111; end
        endcase
        end_off  = off + {31'h0, nbytes};
        acc_err  = (req_size == 2'd3) | off[33] | (end_off > LIMIT);
        lane     = off[1:0];
        idx      = off[AW+1:2];
        crossing = !acc_err && (((req_size == 2'd1) && (lane == 2'd3)) ||
                                ((req_size == 2'd2) && (lane != 2'd0)));
        be8      = {4'h0, size_mask} << lane;
        wdata64  = {32'h0, req_wdata} << {lane, 3'b000};
        accept   = req_valid & req_ready;
    end

    // Asynchronous array reads so a load sees a store committed one edge earlier.
    always_comb begin
        rd_lo     = mem[idx];
        rd_hi     = mem[sp_idx];
        ld_raw_lo = rd_lo >> {lane, 3'b000};
        split64   = {rd_hi, sp_lo} >> {sp_lane, 3'b000};
    end

    // Select the single write for this cycle; nothing is written while in reset.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = 4'h0;
        wr_data = 32'h0;
        if (rst_n) begin
            if (state == SPLIT) begin
                if (sp_we) begin
                    wr_en   = 1'b1;
                    wr_idx  = sp_idx;
                    wr_be   = sp_be_hi;
                    wr_data = sp_wdata_hi;
                end
            end else if (accept && req_we && !acc_err) begin
                wr_en   = 1'b1;
                wr_idx  = idx;
                wr_be   = be8[3:0];
                wr_data = wdata64[31:0];
            end
        end
    end

    // Byte-lane writes into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Capture what the second half of a crossing access needs.
    always_ff @(posedge clk) begin
        if (accept && crossing && (state == IDLE)) begin
            sp_idx      <= idx + AW'(1);
            sp_we       <= req_we;
            sp_be_hi    <= be8[7:4];
            sp_wdata_hi <= wdata64[63:32];
            sp_lo       <= rd_lo;
            sp_lane     <= lane;
            sp_size     <= req_size;
            sp_uns      <= req_unsigned;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (crossing) begin
                            state     <= SPLIT;
                            req_ready <= 1'b0;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= acc_err;
                            rsp_rdata <= (acc_err || req_we) ? 32'h0
                                       : extend(ld_raw_lo, req_size, req_unsigned);
                        end
                    end
                end
                SPLIT: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= sp_we ? 32'h0 : extend(split64[31:0], sp_size, sp_uns);
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: byte-array reference model, per-cycle response
// checker, and directed vectors carrying hand-computed expected load values.
module tb_data_mem_sync;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h00001000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_sync #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        bit          lit_en;
        logic [31:0] lit;
        logic        lit_err;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mdl [4*DEPTH];
    int          cyc = 0;
    int          busy_cyc = -1;
    bit          chk_en = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // response checker: every cycle, the DUT must match the scheduled expectations
    always @(negedge clk) begin
        if (chk_en) begin
            bit   exp_v;
            exp_t e;
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v);
            end
            if (exp_v) begin
                e = q.pop_front();
                checks++;
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_model cyc=%0d got rdata=%h err=%b exp rdata=%h err=%b",
                             cyc, rsp_rdata, rsp_err, e.rdata, e.err);
                end
                if (e.lit_en) begin
                    checks++;
                    if (rsp_rdata !== e.lit || rsp_err !== e.lit_err) begin
                        errors++;
                        $display("FAIL rsp_literal cyc=%0d got rdata=%h err=%b exp rdata=%h err=%b",
                                 cyc, rsp_rdata, rsp_err, e.lit, e.lit_err);
                    end
                end
            end
            checks++;
            if (req_ready !== (cyc != busy_cyc)) begin
                errors++;
                $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, cyc != busy_cyc);
            end
        end
    end

    // Issue one request at a negedge; update the model at the acceptance point.
    // abort: assert reset during the split cycle of a crossing access.
    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit lit_en, input logic [31:0] lit, input bit lit_err,
                          input bit abort);
        int          waited = 0;
        longint      off;
        int          n, lane, lat, acc;
        bit          err;
        logic [31:0] rd;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        while (req_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout addr=%h got ready=%b exp=1", addr, req_ready);
            req_valid = 1'b0;
            return;
        end
        off = longint'(addr) - longint'(BASE);
        n   = 1 << sz;
        err = (sz == 2'd3) || (off < 0) || (off + n > 4 * DEPTH);
        lat = 1;
        rd  = 32'h0;
        if (!err) begin
            lane = int'(off % 4);
            if (lane + n > 4) lat = 2;
            for (int i = 0; i < n; i++) begin
                if (we) begin
                    if (!abort || lane + i < 4) mdl[int'(off) + i] = wd[8*i +: 8];
                end else begin
                    rd[8*i +: 8] = mdl[int'(off) + i];
                end
            end
            if (!we && !uns && n == 1 && rd[7])  rd[31:8]  = 24'hFFFFFF;
            if (!we && !uns && n == 2 && rd[15]) rd[31:16] = 16'hFFFF;
        end
        acc = cyc + 1;
        if (lat == 2) busy_cyc = acc;
        if (!abort) q.push_back('{acc + lat - 1, rd, err, lit_en, lit, lit_err});
        @(negedge clk);
        req_valid = 1'b0;
        if (abort) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        do_req(1'b1, sz, 1'b0, addr, wd, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                      input logic [31:0] lit);
        do_req(1'b0, sz, uns, addr, 32'h0, 1'b1, lit, 1'b0, 1'b0);
    endtask

    task automatic bad(input bit we, input logic [1:0] sz, input logic [31:0] addr);
        do_req(we, sz, 1'b0, addr, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4 * DEPTH; i++) mdl[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end

        // known contents for the region used below
        for (int w = 0; w < 6; w++) st(2'd2, BASE + 32'(4 * w), 32'h0);
        st(2'd2, 32'h00001FFC, 32'h11223344);

        // T2 word store then signed/unsigned byte loads
        st(2'd2, 32'h00001000, 32'h8899AABB);
        ld(2'd0, 1'b0, 32'h00001003, 32'hFFFFFF88);
        ld(2'd0, 1'b1, 32'h00001003, 32'h00000088);
        ld(2'd1, 1'b0, 32'h00001000, 32'hFFFFAABB);

        // T3 crossing half store, then reads of both words
        st(2'd1, 32'h00001003, 32'h00001234);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL split_ready got=%b exp=0", req_ready);
        end
        ld(2'd2, 1'b0, 32'h00001000, 32'h3499AABB);
        ld(2'd2, 1'b0, 32'h00001004, 32'h00000012);
        ld(2'd1, 1'b1, 32'h00001003, 32'h00001234);
        ld(2'd2, 1'b0, 32'h00001001, 32'h123499AA);

        // T4 range and size errors, boundaries
        bad(1'b0, 2'd2, 32'h00000FFC);
        bad(1'b1, 2'd2, 32'h00001FFE);
        ld(2'd2, 1'b0, 32'h00001FFC, 32'h11223344);
        bad(1'b0, 2'd3, 32'h00001000);
        ld(2'd0, 1'b0, 32'h00001FFF, 32'h00000011);
        bad(1'b0, 2'd1, 32'h00002000);

        // T5 back-to-back store/load
        st(2'd2, 32'h00001010, 32'hDEADBEEF);
        ld(2'd2, 1'b0, 32'h00001010, 32'hDEADBEEF);
        ld(2'd1, 1'b0, 32'h00001012, 32'hFFFFDEAD);

        // T6 reset during the split cycle of a crossing store
        do_req(1'b1, 2'd2, 1'b0, 32'h00001002, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1'b1);
        ld(2'd2, 1'b0, 32'h00001000, 32'hF00DAABB);
        ld(2'd2, 1'b0, 32'h00001004, 32'h00000012);

        // still functional after the aborted access
        st(2'd0, 32'h00001005, 32'h000000C3);
        ld(2'd0, 1'b0, 32'h00001005, 32'hFFFFFFC3);

        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
